// File: rtl/cdc_rst_pkg.sv
// Shared types and helpers for the reset-request receiver.
// Holds the receiver FSM state encoding and the counter-width calculation.
package cdc_rst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLD,
    RELEASE
  } rst_rx_state_e;

  // The counter is sized for the longer of the two timed phases.
  function automatic int cnt_width(input int min_pulse, input int release_delay);
    int longest;
    longest = (min_pulse > release_delay) ? min_pulse : release_delay;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/cdc_rst_req_receiver_if.sv
// Reset-request handshake bundle between a source domain and the receiver.
// The master is the requesting side; the slave is the receiver.
interface cdc_rst_req_receiver_if;

  logic rst_req_async;
  logic rst_ack;
  logic rst_out;
  logic rst_done;
  logic err_early_drop;
  logic err_reassert;
  logic err_clr;

  modport master (
    output rst_req_async, err_clr,
    input  rst_ack, rst_out, rst_done, err_early_drop, err_reassert
  );

  modport slave (
    input  rst_req_async, err_clr,
    output rst_ack, rst_out, rst_done, err_early_drop, err_reassert
  );

endinterface

// File: rtl/cdc_sync_bit.sv
// N-flop single-bit synchronizer for a level crossing into the clk domain.
// Every stage clears on the synchronous reset so the output starts at 0.
module cdc_sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  // NOTE: non-blocking assignments make every stage sample the pre-edge value,
  // which is what turns this into a shift chain rather than a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/cdc_rst_req_receiver.sv
// Destination end of a 4-phase reset-request handshake: synchronizes the request,
// drives a local reset with minimum pulse and release delay, and flags misuse.
module cdc_rst_req_receiver #(
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_PULSE     = 4,
  parameter int RELEASE_DELAY = 3
) (
  input logic                   clk,
  input logic                   rst,
  cdc_rst_req_receiver_if.slave bus
);

  import cdc_rst_pkg::*;

  localparam int            CW         = cnt_width(MIN_PULSE, RELEASE_DELAY);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(MIN_PULSE - 1);
  localparam logic [CW-1:0] REL_LOAD   = CW'(RELEASE_DELAY - 1);

  rst_rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          out_q;
  logic          done_q, done_d;
  logic          early_q, early_d;
  logic          reassert_q, reassert_d;
  logic          early_evt, reassert_evt;
  logic          req_s;

  cdc_sync_bit #(.N(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rst_req_async),
    .q_o (req_s)
  );

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ack_d        = ack_q;
    done_d       = 1'b0;
    early_evt    = 1'b0;
    reassert_evt = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = ASSERT;
          cnt_d   = PULSE_LOAD;
        end
      end
      ASSERT: begin
        // A drop here is a protocol error, but the minimum pulse still runs out.
        early_evt = ~req_s;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (req_s) begin
          state_d = HOLD;
          ack_d   = 1'b1;
        end else begin
          state_d = RELEASE;
          cnt_d   = REL_LOAD;
        end
      end
      HOLD: begin
        if (!req_s) begin
          state_d = RELEASE;
          cnt_d   = REL_LOAD;
        end
      end
      RELEASE: begin
        if (req_s) begin
          // Re-entering ASSERT keeps rst_out high; only a re-raise after ack is an error.
          state_d      = ASSERT;
          cnt_d        = PULSE_LOAD;
          reassert_evt = ack_q;
          ack_d        = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
          ack_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = RELEASE;
        cnt_d   = REL_LOAD;
      end
    endcase

    // A new error event beats a simultaneous clear.
    early_d    = early_evt    | (early_q    & ~bus.err_clr);
    reassert_d = reassert_evt | (reassert_q & ~bus.err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RELEASE;
      cnt_q      <= REL_LOAD;
      out_q      <= 1'b1;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      early_q    <= 1'b0;
      reassert_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_q      <= (state_d != IDLE);
      ack_q      <= ack_d;
      done_q     <= done_d;
      early_q    <= early_d;
      reassert_q <= reassert_d;
    end
  end

  assign bus.rst_out        = out_q;
  assign bus.rst_ack        = ack_q;
  assign bus.rst_done       = done_q;
  assign bus.err_early_drop = early_q;
  assign bus.err_reassert   = reassert_q;

endmodule

// File: tb/tb_cdc_rst_req_receiver.sv
// Directed bench for cdc_rst_req_receiver with default parameters (2/4/3).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_cdc_rst_req_receiver;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  cdc_rst_req_receiver_if bus ();

  cdc_rst_req_receiver #(
    .SYNC_STAGES   (2),
    .MIN_PULSE     (4),
    .RELEASE_DELAY (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed outputs packed as {rst_out, rst_ack, rst_done, err_early_drop, err_reassert}.
  function automatic logic [4:0] obs();
    return {bus.rst_out, bus.rst_ack, bus.rst_done, bus.err_early_drop, bus.err_reassert};
  endfunction

  // rst held for three edges; edge 0 is the last one with rst high.
  task automatic test_reset();
    logic [4:0] exp;
    rst = 1'b1;
    bus.rst_req_async = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      if (e > 0) tick();
      exp = {(e < 3), 1'b0, (e == 3), 2'b00};
      n_checks++;
      if (obs() !== exp)
        $display("FAIL reset edge %0d: got %b want %b (out,ack,done,early,reassert)", e, obs(), exp);
      else n_pass++;
    end
  endtask

  // Request rises after edge 0 and falls after edge 10.
  task automatic test_nominal();
    logic [4:0] exp;
    bus.rst_req_async = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      exp = {(e >= 3 && e <= 15), (e >= 7 && e <= 15), (e == 16), 2'b00};
      n_checks++;
      if (obs() !== exp)
        $display("FAIL nominal edge %0d: got %b want %b (out,ack,done,early,reassert)", e, obs(), exp);
      else n_pass++;
      if (e == 10) bus.rst_req_async = 1'b0;
    end
  endtask

  // Request high for two cycles only: full 4+3 pulse, no ack, sticky early-drop flag.
  task automatic test_early_drop();
    logic [4:0] exp;
    bus.rst_req_async = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp = {(e >= 3 && e <= 9), 1'b0, (e == 10), (e >= 5), 1'b0};
      n_checks++;
      if (obs() !== exp)
        $display("FAIL early_drop edge %0d: got %b want %b (out,ack,done,early,reassert)", e, obs(), exp);
      else n_pass++;
      if (e == 2) bus.rst_req_async = 1'b0;
    end
  endtask

  // After ack, request drops for one cycle and returns while in RELEASE.
  task automatic test_reassert();
    logic [4:0] exp;
    bus.rst_req_async = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      exp = {1'(e >= 3), ((e >= 7 && e <= 11) || e >= 16), 1'b0, 1'b1, (e >= 12)};
      n_checks++;
      if (obs() !== exp)
        $display("FAIL reassert edge %0d: got %b want %b (out,ack,done,early,reassert)", e, obs(), exp);
      else n_pass++;
      if (e == 8) bus.rst_req_async = 1'b0;
      if (e == 9) bus.rst_req_async = 1'b1;
    end
  endtask

  // err_clr alone clears both flags; err_clr on the cycle of a new early drop loses.
  task automatic test_err_clr();
    logic [4:0] exp;
    bus.err_clr = 1'b1;
    tick();
    exp = 5'b11000;
    n_checks++;
    if (obs() !== exp)
      $display("FAIL err_clr_alone: got %b want %b (out,ack,done,early,reassert)", obs(), exp);
    else n_pass++;
    bus.err_clr = 1'b0;
    bus.rst_req_async = 1'b0;
    for (int e = 2; e <= 19; e++) begin
      tick();
      exp = {((e <= 6) || (e >= 11 && e <= 17)), (e <= 6), ((e == 7) || (e == 18)), (e >= 13), 1'b0};
      n_checks++;
      if (obs() !== exp)
        $display("FAIL err_clr edge %0d: got %b want %b (out,ack,done,early,reassert)", e, obs(), exp);
      else n_pass++;
      if (e == 8)  bus.rst_req_async = 1'b1;
      if (e == 10) bus.rst_req_async = 1'b0;
      if (e == 12) bus.err_clr = 1'b1;
      if (e == 13) bus.err_clr = 1'b0;
    end
  endtask

  // Early drop then re-raise while in RELEASE with ack low: legal, rst_out unbroken.
  task automatic test_back_to_back();
    logic [4:0] exp;
    bus.err_clr = 1'b1;
    bus.rst_req_async = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick();
      exp = {1'(e >= 3), 1'(e >= 12), 1'b0, 1'(e >= 5), 1'b0};
      n_checks++;
      if (obs() !== exp)
        $display("FAIL back_to_back edge %0d: got %b want %b (out,ack,done,early,reassert)", e, obs(), exp);
      else n_pass++;
      if (e == 1) bus.err_clr = 1'b0;
      if (e == 2) bus.rst_req_async = 1'b0;
      if (e == 5) bus.rst_req_async = 1'b1;
    end
  endtask

  // One-edge rst pulse while in HOLD with the request dropping at the same time.
  task automatic test_mid_reset();
    logic [4:0] exp;
    rst = 1'b1;
    bus.rst_req_async = 1'b0;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      if (e > 1) tick();
      exp = {(e <= 3), 1'b0, (e == 4), 2'b00};
      n_checks++;
      if (obs() !== exp)
        $display("FAIL mid_reset edge %0d: got %b want %b (out,ack,done,early,reassert)", e, obs(), exp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_early_drop();
    test_reassert();
    test_err_clr();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
